// File: rtl/gcm_pkt_sequencer_if.sv
// rtl/gcm_pkt_sequencer_if.sv - stream, key and core-side signal bundle for gcm_pkt_sequencer
interface gcm_pkt_sequencer_if #(
    parameter int NUM_LANES = 2,
    parameter int BYPASS_W  = 289,
    parameter int IDX_W     = 12
);
    logic                      i_valid;
    logic                      i_new;
    logic                      i_last;
    logic [128*NUM_LANES-1:0]  i_plain_text;
    logic [BYPASS_W-1:0]       i_bypass_text;
    logic                      i_key_we;
    logic [127:0]              i_key;
    logic [95:0]               i_iv;
    logic                      o_core_new;
    logic                      o_core_last;
    logic [128*NUM_LANES-1:0]  o_core_pt;
    logic [63:0]               o_core_pt_size;
    logic [127:0]              o_core_key;
    logic [95:0]               o_core_iv;
    logic                      i_core_ready;
    logic [128*NUM_LANES-1:0]  i_core_cipher;
    logic                      o_valid;
    logic [128*NUM_LANES-1:0]  o_cipher_text;
    logic [BYPASS_W-1:0]       o_bypass_text;
    logic [1:0]                o_state;
    logic [IDX_W-1:0]          o_word_idx;
    logic                      o_pkt_err;
    logic                      o_lat_err;

    modport slave (
        input  i_valid, i_new, i_last, i_plain_text, i_bypass_text,
        input  i_key_we, i_key, i_iv, i_core_ready, i_core_cipher,
        output o_core_new, o_core_last, o_core_pt, o_core_pt_size, o_core_key, o_core_iv,
        output o_valid, o_cipher_text, o_bypass_text, o_state, o_word_idx, o_pkt_err, o_lat_err
    );

    modport master (
        output i_valid, i_new, i_last, i_plain_text, i_bypass_text,
        output i_key_we, i_key, i_iv, i_core_ready, i_core_cipher,
        input  o_core_new, o_core_last, o_core_pt, o_core_pt_size, o_core_key, o_core_iv,
        input  o_valid, o_cipher_text, o_bypass_text, o_state, o_word_idx, o_pkt_err, o_lat_err
    );
endinterface

// File: rtl/gcm_pkt_sequencer.sv
// rtl/gcm_pkt_sequencer.sv - N-lane GCM packet sequencer with latency-matched bypass delay line
// Optional key/IV load path enabled by defining GCM_KEY_LOAD_EN.
module gcm_pkt_sequencer #(
    parameter int NUM_LANES = 2,
    parameter int BYPASS_W  = 289,
    parameter int LEN_LSB   = 33,
    parameter int HDR_BYTES = 14,
    parameter int CORE_LAT  = 12,
    parameter int IDX_W     = 12
) (
    input  logic               clk,
    input  logic               reset,
    gcm_pkt_sequencer_if.slave bus
);
    localparam int PT_W  = 128 * NUM_LANES;
    localparam int DLY_N = CORE_LAT + 1;

    typedef enum logic [1:0] {ST_FIRST = 2'd0, ST_SECOND = 2'd1, ST_INNER = 2'd2} state_t;

    typedef struct packed {
        logic                valid;
        logic [1:0]          state;
        logic [IDX_W-1:0]    idx;
        logic [BYPASS_W-1:0] byp;
    } dly_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d, cur_idx;
    logic [63:0]         size_q, size_d;
    logic [15:0]         len;
    logic [63:0]         len64;
    logic                core_new_q, core_new_d;
    logic                core_last_q, core_last_d;
    logic [PT_W-1:0]     core_pt_q, core_pt_d;
    logic                pkt_err_q, pkt_err_d;
    dly_t                dly_q [DLY_N];
    dly_t                dly_d [DLY_N];
    logic                out_valid_q, out_valid_d;
    logic [1:0]          out_state_q, out_state_d;
    logic [IDX_W-1:0]    out_idx_q, out_idx_d;
    logic [BYPASS_W-1:0] out_byp_q, out_byp_d;
    logic [PT_W-1:0]     out_ct_q, out_ct_d;
    logic                lat_err_q, lat_err_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        size_d      = size_q;
        pkt_err_d   = 1'b0;
        len         = bus.i_bypass_text[LEN_LSB +: 16];
        len64       = {48'd0, len};
        cur_idx     = (state_q == ST_FIRST) ? '0 : idx_q;

        if (bus.i_valid) begin
            if (bus.i_new) begin
                idx_d = (&cur_idx) ? cur_idx : cur_idx + IDX_W'(1);
                if (bus.i_last) begin
                    state_d = ST_FIRST;
                end else begin
                    case (state_q)
                        ST_FIRST:  state_d = ST_SECOND;
                        ST_SECOND: state_d = ST_INNER;
                        ST_INNER:  state_d = ST_INNER;
                        default:   state_d = ST_FIRST;
                    endcase
                end
                // Size comes from the header word only and is held for the packet.
                if (state_q == ST_FIRST) begin
                    size_d = (len >= 16'(HDR_BYTES)) ? ((len64 - 64'(HDR_BYTES)) << 3) : 64'd0;
                end
            end else begin
                idx_d     = '0;
                pkt_err_d = (state_q != ST_FIRST);
                state_d   = ST_FIRST;
            end
        end

        core_new_d  = bus.i_valid & bus.i_new;
        core_last_d = bus.i_valid & bus.i_last;
        core_pt_d   = bus.i_plain_text;

        dly_d[0].valid = bus.i_valid;
        dly_d[0].state = state_q;
        dly_d[0].idx   = cur_idx;
        dly_d[0].byp   = bus.i_bypass_text;
        for (int k = 1; k < DLY_N; k++) begin
            dly_d[k] = dly_q[k-1];
        end

        // Stage-out lines up with the cycle the core reports its result.
        out_valid_d = dly_q[DLY_N-1].valid;
        out_state_d = dly_q[DLY_N-1].state;
        out_idx_d   = dly_q[DLY_N-1].idx;
        out_byp_d   = dly_q[DLY_N-1].byp;
        out_ct_d    = bus.i_core_cipher;
        lat_err_d   = lat_err_q | (dly_q[DLY_N-1].valid != bus.i_core_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_FIRST;
            idx_q       <= '0;
            size_q      <= '0;
            core_new_q  <= 1'b0;
            core_last_q <= 1'b0;
            core_pt_q   <= '0;
            pkt_err_q   <= 1'b0;
            for (int k = 0; k < DLY_N; k++) begin
                dly_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            out_state_q <= 2'd0;
            out_idx_q   <= '0;
            out_byp_q   <= '0;
            out_ct_q    <= '0;
            lat_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            size_q      <= size_d;
            core_new_q  <= core_new_d;
            core_last_q <= core_last_d;
            core_pt_q   <= core_pt_d;
            pkt_err_q   <= pkt_err_d;
            for (int k = 0; k < DLY_N; k++) begin
                dly_q[k] <= dly_d[k];
            end
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
            out_idx_q   <= out_idx_d;
            out_byp_q   <= out_byp_d;
            out_ct_q    <= out_ct_d;
            lat_err_q   <= lat_err_d;
        end
    end

`ifdef GCM_KEY_LOAD_EN
    logic [127:0] key_q, key_d;
    logic [95:0]  iv_q, iv_d;

    // Loads are accepted only between packets so a packet never sees a key change.
    always_comb begin
        key_d = key_q;
        iv_d  = iv_q;
        if (bus.i_key_we && (state_q == ST_FIRST)) begin
            key_d = bus.i_key;
            iv_d  = bus.i_iv;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q <= '0;
            iv_q  <= '0;
        end else begin
            key_q <= key_d;
            iv_q  <= iv_d;
        end
    end

    assign bus.o_core_key = key_q;
    assign bus.o_core_iv  = iv_q;
`else
    logic unused_key;
    assign unused_key     = ^{bus.i_key_we, bus.i_key, bus.i_iv};
    assign bus.o_core_key = '0;
    assign bus.o_core_iv  = '0;
`endif

    assign bus.o_core_new     = core_new_q;
    assign bus.o_core_last    = core_last_q;
    assign bus.o_core_pt      = core_pt_q;
    assign bus.o_core_pt_size = size_q;
    assign bus.o_pkt_err      = pkt_err_q;
    assign bus.o_valid        = out_valid_q;
    assign bus.o_state        = out_state_q;
    assign bus.o_word_idx     = out_idx_q;
    assign bus.o_bypass_text  = out_byp_q;
    assign bus.o_cipher_text  = out_ct_q;
    assign bus.o_lat_err      = lat_err_q;
endmodule

// File: tb/tb_gcm_pkt_sequencer.sv
// tb/tb_gcm_pkt_sequencer.sv - scoreboard bench for gcm_pkt_sequencer with a delay-line core model
module tb_gcm_pkt_sequencer;
    localparam int NL = 2;
    localparam int BW = 289;
    localparam int LL = 33;
    localparam int HB = 14;
    localparam int CL = 5;
    localparam int IW = 3;
    localparam int PW = 128 * NL;
    localparam logic [PW-1:0] MASK = {(PW/32){32'hA5C3_0F96}};

    logic clk = 1'b0;
    logic reset;
    bit   late;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gcm_pkt_sequencer_if #(.NUM_LANES(NL), .BYPASS_W(BW), .IDX_W(IW)) bus ();

    gcm_pkt_sequencer #(
        .NUM_LANES(NL), .BYPASS_W(BW), .LEN_LSB(LL),
        .HDR_BYTES(HB), .CORE_LAT(CL), .IDX_W(IW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Core model: result ready CL cycles after the registered core input.
    logic [CL+1:0] vpipe;
    logic [PW-1:0] ppipe [CL+1];
    always @(posedge clk) begin
        if (reset) vpipe <= '0;
        else       vpipe <= {vpipe[CL:0], bus.i_valid};
        ppipe[0] <= bus.i_plain_text;
        for (int k = 1; k <= CL; k++) ppipe[k] <= ppipe[k-1];
    end
    assign bus.i_core_ready  = late ? vpipe[CL+1] : vpipe[CL];
    assign bus.i_core_cipher = ppipe[CL] ^ MASK;

    typedef struct {
        logic [1:0]    st;
        logic [IW-1:0] idx;
        logic [BW-1:0] byp;
        logic [PW-1:0] ct;
        int            t;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!reset && bus.o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 512'(1), 512'(0));
            end else begin
                e = sb.pop_front();
                check("out_state",   512'(bus.o_state),       512'(e.st));
                check("out_idx",     512'(bus.o_word_idx),    512'(e.idx));
                check("out_bypass",  512'(bus.o_bypass_text), 512'(e.byp));
                check("out_cipher",  512'(bus.o_cipher_text), 512'(e.ct));
                check("out_latency", 512'(cyc - e.t),         512'(CL + 2));
            end
        end
    end

    task automatic send(input bit n, input bit l, input logic [15:0] len,
                        input logic [1:0] est, input logic [IW-1:0] eidx,
                        input logic [63:0] esize, input bit csize, input bit eerr);
        logic [PW-1:0]  pt;
        logic [319:0]   tmp;
        logic [BW-1:0]  byp;
        exp_t           e;
        for (int k = 0; k < PW/32; k++) pt[32*k +: 32] = $urandom;
        for (int k = 0; k < 10; k++) tmp[32*k +: 32] = $urandom;
        byp = tmp[BW-1:0];
        byp[LL +: 16] = len;
        @(negedge clk);
        bus.i_valid       = 1'b1;
        bus.i_new         = n;
        bus.i_last        = l;
        bus.i_plain_text  = pt;
        bus.i_bypass_text = byp;
        e.st = est; e.idx = eidx; e.byp = byp; e.ct = pt ^ MASK; e.t = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.i_valid  = 1'b0;
        bus.i_key_we = 1'b0;
        check("core_new",  512'(bus.o_core_new),  512'(n));
        check("core_last", 512'(bus.o_core_last), 512'(l));
        check("core_pt",   512'(bus.o_core_pt),   512'(pt));
        check("pkt_err",   512'(bus.o_pkt_err),   512'(eerr));
        if (csize) check("pt_size", 512'(bus.o_core_pt_size), 512'(esize));
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            #2;
            k++;
        end
        check("drain_timeout", 512'(sb.size()), 512'(0));
    endtask

    task automatic check_zero(input string p);
        check({p, "_valid"},     512'(bus.o_valid),        512'(0));
        check({p, "_core_new"},  512'(bus.o_core_new),     512'(0));
        check({p, "_core_last"}, 512'(bus.o_core_last),    512'(0));
        check({p, "_pkt_err"},   512'(bus.o_pkt_err),      512'(0));
        check({p, "_lat_err"},   512'(bus.o_lat_err),      512'(0));
        check({p, "_core_pt"},   512'(bus.o_core_pt),      512'(0));
        check({p, "_size"},      512'(bus.o_core_pt_size), 512'(0));
        check({p, "_state"},     512'(bus.o_state),        512'(0));
        check({p, "_idx"},       512'(bus.o_word_idx),     512'(0));
        check({p, "_bypass"},    512'(bus.o_bypass_text),  512'(0));
        check({p, "_cipher"},    512'(bus.o_cipher_text),  512'(0));
        check({p, "_key"},       512'(bus.o_core_key),     512'(0));
        check({p, "_iv"},        512'(bus.o_core_iv),      512'(0));
    endtask

    task automatic load_key(input logic [127:0] k, input logic [95:0] v);
        @(negedge clk);
        bus.i_key_we = 1'b1;
        bus.i_key    = k;
        bus.i_iv     = v;
        @(posedge clk);
        #1;
        bus.i_key_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        late  = 1'b0;
        bus.i_valid = 1'b0; bus.i_new = 1'b0; bus.i_last = 1'b0;
        bus.i_plain_text = '0; bus.i_bypass_text = '0;
        bus.i_key_we = 1'b0; bus.i_key = '0; bus.i_iv = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst");
        @(negedge clk);
        reset = 1'b0;

        send(1, 0, 16'd78,  2'd0, 3'd0, 64'd512, 1, 0);
        send(1, 0, 16'd300, 2'd1, 3'd1, 64'd512, 1, 0);
        send(1, 1, 16'd5,   2'd2, 3'd2, 64'd512, 1, 0);
        send(1, 1, 16'd20,  2'd0, 3'd0, 64'd48,  1, 0);
        send(1, 0, 16'd10,  2'd0, 3'd0, 64'd0,   1, 0);
        send(1, 1, 16'd90,  2'd1, 3'd1, 64'd0,   1, 0);
        send(1, 1, 16'd14,  2'd0, 3'd0, 64'd0,   1, 0);
        send(1, 1, 16'd15,  2'd0, 3'd0, 64'd8,   1, 0);
        send(1, 1, 16'hFFFF, 2'd0, 3'd0, 64'h7FF88, 1, 0);
        send(0, 0, 16'd33,  2'd0, 3'd0, 64'd0,   0, 0);

        send(1, 0, 16'd40,  2'd0, 3'd0, 64'd208, 1, 0);
        send(1, 0, 16'd41,  2'd1, 3'd1, 64'd208, 1, 0);
        send(1, 0, 16'd42,  2'd2, 3'd2, 64'd208, 1, 0);
        send(0, 0, 16'd43,  2'd2, 3'd3, 64'd208, 0, 1);
        send(1, 1, 16'd15,  2'd0, 3'd0, 64'd8,   1, 0);

        for (int i = 0; i < 10; i++) begin
            send(1, (i == 9), 16'd100, (i == 0) ? 2'd0 : ((i == 1) ? 2'd1 : 2'd2),
                 (i > 7) ? 3'd7 : 3'(i), 64'd688, 1, 0);
        end
        drain();
        check("lat_err_clean", 512'(bus.o_lat_err), 512'(0));

`ifdef GCM_KEY_LOAD_EN
        load_key(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 96'hCAFE_F00D_1234_5678_9ABC_DEF0);
        check("key_load_first", 512'(bus.o_core_key), 512'(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210));
        check("iv_load_first",  512'(bus.o_core_iv),  512'(96'hCAFE_F00D_1234_5678_9ABC_DEF0));
        send(1, 0, 16'd30, 2'd0, 3'd0, 64'd128, 1, 0);
        send(1, 0, 16'd31, 2'd1, 3'd1, 64'd128, 1, 0);
        bus.i_key_we = 1'b1;
        bus.i_key    = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        bus.i_iv     = 96'h9999_AAAA_BBBB_CCCC_DDDD_EEEE;
        send(1, 0, 16'd32, 2'd2, 3'd2, 64'd128, 1, 0);
        check("key_inner_ignored", 512'(bus.o_core_key), 512'(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210));
        send(1, 1, 16'd33, 2'd2, 3'd3, 64'd128, 1, 0);
        load_key(128'h1111_2222_3333_4444_5555_6666_7777_8888, 96'h9999_AAAA_BBBB_CCCC_DDDD_EEEE);
        check("key_load_between", 512'(bus.o_core_key), 512'(128'h1111_2222_3333_4444_5555_6666_7777_8888));
        check("iv_load_between",  512'(bus.o_core_iv),  512'(96'h9999_AAAA_BBBB_CCCC_DDDD_EEEE));
`else
        load_key(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 96'hCAFE_F00D_1234_5678_9ABC_DEF0);
        check("key_const_zero", 512'(bus.o_core_key), 512'(0));
        check("iv_const_zero",  512'(bus.o_core_iv),  512'(0));
`endif

        send(1, 0, 16'd50, 2'd0, 3'd0, 64'd288, 1, 0);
        send(1, 0, 16'd51, 2'd1, 3'd1, 64'd288, 1, 0);
        @(negedge clk);
        reset = 1'b1;
        bus.i_valid = 1'b1; bus.i_new = 1'b1; bus.i_last = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        check_zero("midrst");
        @(negedge clk);
        reset = 1'b0;
        bus.i_valid = 1'b0;
        repeat (CL + 4) @(posedge clk);
        send(1, 1, 16'd20, 2'd0, 3'd0, 64'd48, 1, 0);
        drain();
        check("lat_err_after_rst", 512'(bus.o_lat_err), 512'(0));

        late = 1'b1;
        send(1, 1, 16'd20, 2'd0, 3'd0, 64'd48, 1, 0);
        drain();
        check("lat_err_set", 512'(bus.o_lat_err), 512'(1));
        repeat (4) @(posedge clk);
        #1;
        check("lat_err_sticky", 512'(bus.o_lat_err), 512'(1));
        @(negedge clk);
        reset = 1'b1;
        late  = 1'b0;
        @(posedge clk);
        #1;
        check("lat_err_cleared", 512'(bus.o_lat_err), 512'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (CL + 4) @(posedge clk);
        #1;
        check("lat_err_stays_clear", 512'(bus.o_lat_err), 512'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/gcm_pkt_sequencer.md
# gcm_pkt_sequencer

Parametrised packet sequencer between the packet stream and an array of `gcm_aes` cores. It tracks the word position of each packet and derives the plaintext bit length from the header length field, saturating at zero. It fans plaintext lanes out to `NUM_LANES` cores and carries bypass metadata through a delay line matched to the core latency. It then re-joins that metadata with the returned ciphertext. It generalises the fixed two-lane, zero-key front end to N lanes, configurable latency, and packet/latency error detection.

## Interface
- `NUM_LANES`, 2, number of 128-bit GCM lanes (1–8)
- `BYPASS_W`, 289, bypass metadata width
- `LEN_LSB`, 33, LSB index of the 16-bit byte-length field in `i_bypass_text`
- `HDR_BYTES`, 14, header bytes excluded from plaintext size
- `CORE_LAT`, 12, cycles from core input to core `o_cp_ready` (≥1)
- `IDX_W`, 12, word-index counter width

Ports:
- `clk` in 1: single clock
- `reset` in 1: synchronous, active-high
- `i_valid` in 1: input word valid
- `i_new` in 1: word belongs to a packet (high on every packet word)
- `i_last` in 1: final word of packet
- `i_plain_text` in `128*NUM_LANES`: lane 0 in the MSBs
- `i_bypass_text` in `BYPASS_W`: metadata
- `i_key_we` in 1: key/IV load strobe
- `i_key` in 128, `i_iv` in 96: key/IV load value
- `o_core_new`, `o_core_last` out 1: to all cores
- `o_core_pt` out `128*NUM_LANES`: registered lanes
- `o_core_pt_size` out 64: plaintext bits
- `o_core_key` out 128, `o_core_iv` out 96: to all cores
- `i_core_ready` in 1: lane 0 core ready
- `i_core_cipher` in `128*NUM_LANES`: from cores
- `o_valid` out 1, `o_cipher_text` out `128*NUM_LANES`, `o_bypass_text` out `BYPASS_W`
- `o_state` out 2: delayed word state (FIRST=0, SECOND=1, INNER=2)
- `o_word_idx` out `IDX_W`: delayed word index
- `o_pkt_err` out 1: pulse
- `o_lat_err` out 1: sticky

## Operation
- FSM `FIRST`/`SECOND`/`INNER` advances only on `i_valid`.
  - `FIRST` + `i_new` + `!i_last` → `SECOND`.
  - `FIRST` + `i_new` + `i_last` → `FIRST`: single-word packet.
  - `SECOND` + `i_new` + `!i_last` → `INNER`.
  - `INNER` + `i_new` + `!i_last` → `INNER`.
  - Any state + `i_new` + `i_last` → `FIRST`.
  - `SECOND` or `INNER` + `!i_new` → `FIRST`, with `o_pkt_err` pulsing high for one cycle (aborted packet).
  - `FIRST` + `!i_new`: word is passed through with `o_core_new`=0; no error.
- Word index resets to 0 on a FIRST-state word and increments per valid packet word. It saturates at all-ones.
- Plaintext size is latched on the FIRST word:
  - len = `i_bypass_text[LEN_LSB+15:LEN_LSB]`.
  - If len ≥ `HDR_BYTES`, size = (len − `HDR_BYTES`) × 8, zero-extended to 64 bits; otherwise size = 0.
  - Held stable for the rest of the packet.
- `o_core_new` = `i_valid & i_new`; `o_core_last` = `i_valid & i_last`. Both are registered one cycle together with `o_core_pt`.
- Delay line, `CORE_LAT`+1 stages, carries {valid, state, word_idx, bypass}. Stage-out drives `o_valid`, `o_state`, `o_word_idx`, `o_bypass_text`. `o_cipher_text` is `i_core_cipher` registered on the same edge.
- Latency check: if delayed valid ≠ `i_core_ready` at stage-out, `o_lat_err` sets and holds until `reset`.
- Reset mid-packet: FSM returns to `FIRST` and the delay line is flushed. No output word from the aborted packet appears.

## Timing
- Core-side outputs: 1 cycle after the input word.
- Stream outputs: `CORE_LAT`+2 cycles after the input word, given a core latency of `CORE_LAT`.
- Throughput: one word per cycle; no backpressure.
- Reset values:
  - `o_valid`, `o_core_new`, `o_core_last`, `o_pkt_err`, `o_lat_err` = 0.
  - All data outputs = 0; `o_state` = FIRST; `o_core_pt_size` = 0.
  - Key and IV registers = 0.
- `i_key_we` while a packet is in flight (state ≠ `FIRST`) is ignored; the key changes only between packets.

## Configuration
- `GCM_KEY_LOAD_EN` defined: key/IV registers load from `i_key`/`i_iv` on `i_key_we` in `FIRST` state.
- `GCM_KEY_LOAD_EN` undefined: `o_core_key` = 0 and `o_core_iv` = 0 constant; `i_key_we`, `i_key` and `i_iv` are unused.

## Test plan
- 3-word packet, len=78:
  - `o_core_pt_size` = 512.
  - `o_state` sequence 0,1,2.
  - `o_word_idx` sequence 0,1,2.
  - Outputs appear at `CORE_LAT`+2.
- Single-word packet (`i_new`=`i_last`=1), len=20: size 48, state stays `FIRST`, next packet starts at idx 0.
- len=10 (< `HDR_BYTES`) → size 0. len=0xFFFF → size 0x7FF88.
- `i_new` drops in `INNER` → one-cycle `o_pkt_err`, FSM in `FIRST`, next packet idx 0.
- Core model with latency `CORE_LAT`+1 → `o_lat_err` sets on the first output and stays set until `reset`.
- `reset` asserted mid-packet → all outputs 0 next cycle. With `GCM_KEY_LOAD_EN`, a key load while in `INNER` is ignored and a key load in `FIRST` takes effect on the next packet.
